// File: rtl/lab_ctrl_param.sv
// lab_ctrl_param: LAB-level control plane.
// Builds the shared 8-bit ALM control bus from the dedicated clock lanes and
// local interconnect, and picks the carry entering each carry group. The
// configuration is streamed into a shadow register and copied to the active
// register on commit, so a new frame can be loaded while the old one is live.
module lab_ctrl_param #(
    parameter int NUM_ALM         = 10,
    parameter int ALMS_PER_GROUP  = 5,
    parameter int NUM_LANES       = 6,
    parameter int CONFIG_W        = 1,
    localparam int NUM_GROUPS     = NUM_ALM / ALMS_PER_GROUP,
    localparam int SEL_W          = $clog2(NUM_LANES + 2),
    localparam int CONFIG_LEN     = NUM_GROUPS + 10 + 3 * SEL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_LANES-1:0]    dedicated_lane_lab_clocks,
    input  logic [6:0]              local_interconnect,
    output logic [7:0]              control_signals,
    input  logic                    carry_in,
    input  logic                    carry_in_previous_lab,
    input  logic [NUM_GROUPS-1:0]   group_carry_out,
    output logic [NUM_GROUPS-1:0]   group_carry_in,
    input  logic [CONFIG_W-1:0]     config_data,
    input  logic                    config_valid,
    output logic                    config_ready,
    input  logic                    config_commit,
    input  logic                    config_abort,
    output logic                    config_done,
    output logic                    config_err,
    output logic [CONFIG_LEN-1:0]   config_active
);

    // Width of the received-bit counter; it must be able to hold CONFIG_LEN.
    localparam int CNT_W = $clog2(CONFIG_LEN + 1);
    // Lowest index of the b3..b12 field inside a frame.
    localparam int B_LSB = 3 * SEL_W;

    // Configuration state
    logic [CONFIG_LEN-1:0] r_active;
    logic [CONFIG_LEN-1:0] r_shadow;
    logic [CNT_W-1:0]      r_bitCount;
    logic                  r_frameFull;
    logic                  r_done;
    logic                  r_err;

    // Loader helpers
    logic                  w_accept;
    logic                  w_commitOk;
    logic                  w_lastBeat;
    logic [CNT_W:0]        w_countSum;
    logic [CNT_W-1:0]      w_take;
    logic [CNT_W-1:0]      w_drop;
    logic [CONFIG_LEN-1:0] w_beatExt;
    logic [CONFIG_LEN-1:0] w_shadowNext;

    // Decoded fields of the active frame
    logic [NUM_GROUPS-1:0] w_carrySel;
    logic [12:3]           w_b;
    logic [SEL_W-1:0]      w_sel0;
    logic [SEL_W-1:0]      w_sel1;
    logic [SEL_W-1:0]      w_sel2;

    // Mux and inversion terms feeding the control bus
    logic w_m0, w_m1, w_m2, w_m3, w_m4;
    logic w_m5, w_m6, w_m7, w_m8, w_m9, w_m10, w_m11, w_m12;

    // The last group's carry-out continues to the next LAB, not into this block.
    logic w_unusedCarryOut;
    assign w_unusedCarryOut = group_carry_out[NUM_GROUPS-1];

    assign config_ready  = !rst && !r_frameFull;
    assign config_done   = r_done;
    assign config_err    = r_err;
    assign config_active = r_active;

    assign w_accept   = config_valid && config_ready;
    assign w_commitOk = config_commit && r_frameFull;

    // Frame layout: the first bit received ends up at the MSB.
    assign w_carrySel = r_active[CONFIG_LEN-1 -: NUM_GROUPS];
    assign w_b        = r_active[B_LSB + 9 : B_LSB];
    assign w_sel2     = r_active[3*SEL_W-1 -: SEL_W];
    assign w_sel1     = r_active[2*SEL_W-1 -: SEL_W];
    assign w_sel0     = r_active[SEL_W-1 : 0];

    // Clock-select mux: lanes first, then local[0], local[1], otherwise 0.
    function automatic logic laneMux(input logic [SEL_W-1:0]     sel,
                                     input logic [NUM_LANES-1:0] lanes,
                                     input logic [1:0]           locals);
        logic result;
        result = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel == SEL_W'(i)) begin
                result = lanes[i];
            end
        end
        if (sel == SEL_W'(NUM_LANES)) begin
            result = locals[0];
        end
        if (sel == SEL_W'(NUM_LANES + 1)) begin
            result = locals[1];
        end
        return result;
    endfunction

    // Work out how many bits of this beat still fit in the frame; on the
    // closing beat only the top bits are kept and the low ones are dropped.
    always_comb begin
        w_countSum   = {1'b0, r_bitCount} + (CNT_W+1)'(CONFIG_W);
        w_lastBeat   = (w_countSum >= (CNT_W+1)'(CONFIG_LEN));
        w_take       = w_lastBeat ? (CNT_W'(CONFIG_LEN) - r_bitCount) : CNT_W'(CONFIG_W);
        w_drop       = CNT_W'(CONFIG_W) - w_take;
        w_beatExt    = CONFIG_LEN'(config_data);
        w_shadowNext = (r_shadow << w_take) | (w_beatExt >> w_drop);
    end

    // Loader and commit sequencing: abort beats commit, commit beats loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active    <= '0;
            r_shadow    <= '0;
            r_bitCount  <= '0;
            r_frameFull <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (config_abort) begin
                r_bitCount  <= '0;
                r_frameFull <= 1'b0;
            end else if (w_commitOk) begin
                r_active    <= r_shadow;
                r_done      <= 1'b1;
                r_bitCount  <= '0;
                r_frameFull <= 1'b0;
            end else if (w_accept) begin
                r_shadow    <= w_shadowNext;
                r_bitCount  <= w_lastBeat ? CNT_W'(CONFIG_LEN) : w_countSum[CNT_W-1:0];
                r_frameFull <= w_lastBeat;
            end
        end
    end

    // Sticky error: a commit arriving before the frame is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (config_commit && !config_abort && !r_frameFull) begin
            r_err <= 1'b1;
        end
    end

    // Control bus: three lane muxes, two local overrides, optional inversions.
    always_comb begin
        w_m0  = laneMux(w_sel0, dedicated_lane_lab_clocks, local_interconnect[1:0]);
        w_m1  = laneMux(w_sel1, dedicated_lane_lab_clocks, local_interconnect[1:0]);
        w_m2  = laneMux(w_sel2, dedicated_lane_lab_clocks, local_interconnect[1:0]);
        w_m3  = w_b[3] ? local_interconnect[4] : w_m0;
        w_m4  = w_b[4] ? local_interconnect[2] : w_m0;
        w_m5  = w_m3 ^ w_b[5];
        w_m6  = w_m4 ^ w_b[6];
        w_m7  = local_interconnect[5] ^ w_b[7];
        w_m8  = local_interconnect[3] ^ w_b[8];
        w_m9  = w_m2 ^ w_b[9];
        w_m10 = w_m1 ^ w_b[10];
        w_m11 = w_m0 ^ w_b[11];
        w_m12 = local_interconnect[6] ^ w_b[12];
        control_signals = {w_m12, w_m11, w_m10, w_m9, w_m8, w_m7, w_m6, w_m5};
    end

    // Carry entry: each group takes the LAB carry-in or the ripple from below.
    always_comb begin
        group_carry_in    = '0;
        group_carry_in[0] = w_carrySel[0] ? carry_in : carry_in_previous_lab;
        for (int g = 1; g < NUM_GROUPS; g++) begin
            group_carry_in[g] = w_carrySel[g] ? carry_in : group_carry_out[g-1];
        end
    end

endmodule

// File: doc/lab_ctrl_param.md
Name: lab_ctrl_param

Overview:
- Parametrised LAB control plane. Generates the shared 8-bit ALM control bus and the per-group carry-entry selection for a LAB of NUM_ALM ALMs split into carry groups.
- Configuration arrives over a word-wide valid/ready port into a shadow register. A commit copies it to the active register, so a new configuration can be loaded while the old one stays live.
- Sits at LAB level between the clock/local routing and the ALM array; the ALM array itself is instantiated outside this block.

Parameters:
- NUM_ALM, 10, ALMs in the LAB; must be a multiple of ALMS_PER_GROUP.
- ALMS_PER_GROUP, 5, ALMs per carry group; NUM_GROUPS = NUM_ALM/ALMS_PER_GROUP.
- NUM_LANES, 6, dedicated LAB clock lanes; SEL_W = clog2(NUM_LANES+2).
- CONFIG_W, 1, configuration bits per accepted beat; range 1..8.

Ports:
- clk  in  1  single clock; all state is on posedge.
- rst  in  1  synchronous, active-high reset.
- dedicated_lane_lab_clocks  in  NUM_LANES  clock lanes.
- local_interconnect  in  7  local control lines.
- control_signals  out  8  {clear_sync_0, clk, clk_HF_controls, clk_HF_data, clk_en_0, clk_en_1, clear_sync_1, clear_async}.
- carry_in  in  1  LAB carry-in.
- carry_in_previous_lab  in  1  carry from the previous LAB.
- group_carry_out  in  NUM_GROUPS  carry-out of each group's last ALM.
- group_carry_in  out  NUM_GROUPS  carry into each group's first ALM.
- config_data  in  CONFIG_W  config beat; bit CONFIG_W-1 is first in order.
- config_valid  in  1  beat valid.
- config_ready  out  1  beat accepted when valid and ready are both high.
- config_commit  in  1  single-cycle pulse: shadow to active.
- config_abort  in  1  discard the partial frame.
- config_done  out  1  one-cycle pulse when a commit takes effect.
- config_err  out  1  sticky error flag.
- config_active  out  CONFIG_LEN  active configuration, for readback.

Behaviour:
- Frame length: CONFIG_LEN = NUM_GROUPS + 10 + 3*SEL_W; 21 with defaults.
- Frame order, first bit received first:
  - carry_sel[NUM_GROUPS-1..0];
  - inv/sel bits b12..b3, b12 first;
  - sel2, then sel1, then sel0, each MSB first.
- Clock-select muxes m0..m2 (select sel0..sel2):
  - sel < NUM_LANES gives lane[sel];
  - sel = NUM_LANES gives local[0];
  - sel = NUM_LANES+1 gives local[1];
  - any other value gives 0.
- Intermediate selects:
  - m3 = b3 ? local[4] : m0.
  - m4 = b4 ? local[2] : m0.
- Optional inversions (each term inverted when its bit is 1):
  - m5 = m3 ^ b5;  m6 = m4 ^ b6;
  - m7 = local[5] ^ b7;  m8 = local[3] ^ b8;
  - m9 = m2 ^ b9;  m10 = m1 ^ b10;  m11 = m0 ^ b11;
  - m12 = local[6] ^ b12.
- control_signals = {m12, m11, m10, m9, m8, m7, m6, m5}. Combinational from the active register; zero latency from data inputs.
- Carry entry:
  - group_carry_in[0] = carry_sel[0] ? carry_in : carry_in_previous_lab.
  - group_carry_in[g>0] = carry_sel[g] ? carry_in : group_carry_out[g-1].
  - Combinational.
- Loading:
  - Each accepted beat shifts CONFIG_W bits into the shadow register and adds CONFIG_W to bit_count.
  - When bit_count + CONFIG_W >= CONFIG_LEN, that beat completes the frame; its bits beyond CONFIG_LEN (lowest indices) are discarded. frame_full is set and bit_count saturates at CONFIG_LEN.
  - config_ready = !rst && !frame_full.
- Commit:
  - Commit with frame_full: active <= shadow on that edge; config_done pulses the next cycle; frame_full and bit_count clear; shadow retained.
  - Commit without frame_full: active unchanged; config_err set; any beat accepted in the same cycle is still taken.
- Abort: clears bit_count and frame_full next edge. A beat in the same cycle is dropped. Abort wins over commit.
- Error: valid && ready with an abort in the same cycle does not set err. config_err clears only on rst.
- Reset (synchronous):
  - active, shadow, bit_count, frame_full, config_done and config_err go to 0; config_ready is 0 while rst is high.
  - Resulting outputs: all selects are lane 0, no inversion, control_signals = {local[6], lane0, lane0, lane0, local[3], local[5], lane0, lane0}.
  - group_carry_in = {group_carry_out[NUM_GROUPS-2:0], carry_in_previous_lab}.
- Reset mid-frame discards the partial frame; reset wins over all other inputs.

Test Plan:
- Reset, all lanes = 6'b000001 -> control_signals[6:0] lane-derived bits = 1; config_ready = 1 from the first cycle after rst falls; config_active = 0.
- Load 21 beats (CONFIG_W=1) with sel0 = 3'b011 and all else 0, then commit -> config_ready falls after beat 21; config_done is high one cycle; control_signals[6] follows lane[3]; lanes toggled 1/0 show zero-cycle propagation.
- Frame with carry_sel = 2'b11 and b11 = 1, committed -> group_carry_in = {carry_in, carry_in}; control_signals[6] = !m0; sel = 3'b110 gives local[0].
- Commit after 10 beats -> config_err = 1 and sticky; config_active unchanged; load the remaining 11 beats and commit -> done pulse, config_err still 1.
- CONFIG_W=4 instance: 6 beats -> frame_full after beat 6; the 3 low bits of beat 6 are discarded; config_active matches the first 21 bits sent.
- Abort at beat 12, or rst at beat 12, then a full new frame -> only the new frame is committed; a commit in the abort cycle is ignored and does not set err.
